// File: rtl/ysyx_22041752_dmem_port.sv
// Data-memory port: one load/store at a time, aligned onto a valid/ready bus; returns the aligned response word.
// Latency: at least 3 cycles from accept to rdata_valid. Backpressure: es_mem_ready low until HOLD+ack.
module ysyx_22041752_dmem_port #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_mem_valid,
  input  logic                 es_mem_we,
  input  logic [ADDR_WD-1:0]   es_mem_addr,
  input  logic [DATA_WD-1:0]   es_mem_wdata,
  input  logic [1:0]           es_mem_bytes,
  output logic                 es_mem_ready,
  output logic [DATA_WD-1:0]   data_rdata,
  output logic                 rdata_valid,
  input  logic                 ms_mem_ack,
  output logic                 dbus_req_valid,
  input  logic                 dbus_req_ready,
  output logic                 dbus_req_we,
  output logic [ADDR_WD-1:0]   dbus_req_addr,
  output logic [DATA_WD-1:0]   dbus_req_wdata,
  output logic [DATA_WD/8-1:0] dbus_req_wstrb,
  input  logic                 dbus_resp_valid,
  input  logic [DATA_WD-1:0]   dbus_resp_data
);

  localparam int STRB_WD = DATA_WD / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic [2:0]           w_off;
  logic [STRB_WD-1:0]   w_strb_base;
  logic [STRB_WD-1:0]   w_wstrb;
  logic [DATA_WD-1:0]   w_wdata;
  logic                 r_we;
  logic [ADDR_WD-1:0]   r_addr;
  logic [DATA_WD-1:0]   r_wdata;
  logic [STRB_WD-1:0]   r_wstrb;
  logic [DATA_WD-1:0]   r_rdata;

  assign w_accept = es_mem_valid && es_mem_ready;
  assign w_off    = es_mem_addr[2:0];

  always_comb begin
    w_strb_base = '0;
    case (es_mem_bytes)
      2'b00:   w_strb_base = STRB_WD'(8'h01);
      2'b01:   w_strb_base = STRB_WD'(8'h03);
      2'b10:   w_strb_base = STRB_WD'(8'h0F);
      default: w_strb_base = STRB_WD'(8'hFF);
    endcase
  end

  // Bytes shifted past the doubleword boundary are simply dropped.
  assign w_wstrb = es_mem_we ? (w_strb_base << w_off) : '0;
  assign w_wdata = es_mem_wdata << {w_off, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      S_REQ:  if (dbus_req_ready) w_next = S_RESP;
      S_RESP: if (dbus_resp_valid) w_next = S_HOLD;
      S_HOLD: if (ms_mem_ack) w_next = w_accept ? S_REQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    es_mem_ready   = 1'b0;
    dbus_req_valid = 1'b0;
    rdata_valid    = 1'b0;
    case (r_state)
      S_IDLE: es_mem_ready = 1'b1;
      S_REQ:  dbus_req_valid = 1'b1;
      S_HOLD: begin
        rdata_valid  = 1'b1;
        es_mem_ready = ms_mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= es_mem_we;
        r_addr  <= {es_mem_addr[ADDR_WD-1:3], 3'b000};
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
      end
      // Stores complete with a zero word so the memory stage never sees stale load data.
      if (r_state == S_RESP && dbus_resp_valid)
        r_rdata <= r_we ? '0 : dbus_resp_data;
    end
  end

  assign dbus_req_we    = r_we;
  assign dbus_req_addr  = r_addr;
  assign dbus_req_wdata = r_wdata;
  assign dbus_req_wstrb = r_wstrb;
  assign data_rdata     = r_rdata;

endmodule
